// File: rtl/mdu_divider_pkg.sv
// Shared M-unit types: operation selects, divider FSM states and default operand width.
package mdu_divider_pkg;

   localparam int unsigned MDU_XLEN = 32;

   // Matches funct3[1:0]; the multiplier's mulsel encoding uses the same field.
   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } divsel_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIN  = 2'b10
   } div_state_e;

endpackage

// File: rtl/mdu_divider_if.sv
// Start/done handshake and operand/result bus between the execute stage and the divider.
interface mdu_divider_if #(
   parameter int unsigned XLEN = mdu_divider_pkg::MDU_XLEN
);

   logic            start_i;
   logic [XLEN-1:0] a_i;
   logic [XLEN-1:0] b_i;
   logic [1:0]      divsel_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] res_o;

   modport master (
      output start_i, a_i, b_i, divsel_i,
      input  busy_o, done_o, res_o
   );

   modport slave (
      input  start_i, a_i, b_i, divsel_i,
      output busy_o, done_o, res_o
   );

endinterface

// File: rtl/mdu_divider_step.sv
// One radix-2 restoring step: shift {rem,quo} left, trial-subtract divisor, keep or restore.
module mdu_div_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_quo,
   input  logic [XLEN:0]   i_div,
   output logic [XLEN-1:0] o_rem,
   output logic [XLEN-1:0] o_quo
);

   logic [XLEN:0]   w_shift;
   logic [XLEN-1:0] w_diff;
   logic            w_fits;

   assign w_shift = {i_rem, i_quo[XLEN-1]};
   assign w_fits  = (w_shift >= i_div);
   // A kept difference is below the divisor, so it always fits in XLEN bits.
   assign w_diff  = XLEN'(w_shift - i_div);
   assign o_rem   = w_fits ? w_diff : w_shift[XLEN-1:0];
   assign o_quo   = {i_quo[XLEN-2:0], w_fits};

endmodule

// File: rtl/mdu_divider.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), XLEN steps per operation.
// MDU_DIV_FAST_SPECIAL_EN: divide-by-zero and INT_MIN/-1 skip the iterations.
module mdu_divider
   import mdu_divider_pkg::*;
#(
   parameter int unsigned XLEN = MDU_XLEN
) (
   input logic          clk_i,
   input logic          rst_i,
   mdu_divider_if.slave bus
);

   localparam int unsigned CntW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e      r_state;
   divsel_e         r_sel;
   logic [CntW-1:0] r_count;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quo;
   logic [XLEN:0]   r_div;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_res;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_bzero;
   logic            r_ovf;
   logic            r_busy;
   logic            r_done;

   divsel_e         w_sel;
   logic            w_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_abs;
   logic [XLEN-1:0] w_b_abs;
   logic            w_bzero;
   logic            w_ovf;
   logic [XLEN-1:0] w_rem_nxt;
   logic [XLEN-1:0] w_quo_nxt;
   logic            w_is_rem;
   logic [XLEN-1:0] w_quo_fix;
   logic [XLEN-1:0] w_rem_fix;
   logic [XLEN-1:0] w_result;

   assign w_sel    = divsel_e'(bus.divsel_i);
   assign w_signed = ~bus.divsel_i[0];
   assign w_a_neg  = w_signed & bus.a_i[XLEN-1];
   assign w_b_neg  = w_signed & bus.b_i[XLEN-1];
   // Magnitude of INT_MIN is exact as an unsigned XLEN value.
   assign w_a_abs  = w_a_neg ? -bus.a_i : bus.a_i;
   assign w_b_abs  = w_b_neg ? -bus.b_i : bus.b_i;
   assign w_bzero  = (bus.b_i == '0);
   assign w_ovf    = w_signed && (bus.a_i == IntMin) && (bus.b_i == '1);

   mdu_div_step #(
      .XLEN (XLEN)
   ) u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_div (r_div),
      .o_rem (w_rem_nxt),
      .o_quo (w_quo_nxt)
   );

   always_comb begin
      w_is_rem  = r_sel inside {REM, REMU};
      w_quo_fix = r_neg_q ? -r_quo : r_quo;
      w_rem_fix = r_neg_r ? -r_rem : r_rem;
      if (r_bzero) begin
         w_result = w_is_rem ? r_a : '1;
      end else if (r_ovf) begin
         w_result = w_is_rem ? '0 : IntMin;
      end else begin
         w_result = w_is_rem ? w_rem_fix : w_quo_fix;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_sel   <= DIV;
         r_count <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_div   <= '0;
         r_a     <= '0;
         r_res   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_bzero <= 1'b0;
         r_ovf   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               // The done cycle is still IDLE but must not accept a new request.
               if (bus.start_i && !r_done) begin
                  r_sel   <= w_sel;
                  r_a     <= bus.a_i;
                  r_rem   <= '0;
                  r_quo   <= w_a_abs;
                  r_div   <= {1'b0, w_b_abs};
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  r_bzero <= w_bzero;
                  r_ovf   <= w_ovf;
                  r_count <= '0;
                  r_busy  <= 1'b1;
`ifdef MDU_DIV_FAST_SPECIAL_EN
                  r_state <= (w_bzero || w_ovf) ? FIN : CALC;
`else
                  r_state <= CALC;
`endif
               end else begin
                  r_busy <= 1'b0;
               end
            end
            CALC: begin
               r_rem   <= w_rem_nxt;
               r_quo   <= w_quo_nxt;
               r_count <= r_count + 1'b1;
               if (r_count == CntW'(XLEN - 1)) begin
                  r_state <= FIN;
               end
            end
            FIN: begin
               r_res   <= w_result;
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy_o = r_busy;
   assign bus.done_o = r_done;
   assign bus.res_o  = r_res;

endmodule

// File: tb/tb_mdu_divider.sv
// Self-checking bench for mdu_divider: cycle-level reference model plus directed vectors.
// Honours MDU_DIV_FAST_SPECIAL_EN for the expected special-case latency.
module tb_mdu_divider;
   import mdu_divider_pkg::*;

   localparam int unsigned W = 32;
   localparam int NormLat = 34;
`ifdef MDU_DIV_FAST_SPECIAL_EN
   localparam int SpecLat = 2;
`else
   localparam int SpecLat = 34;
`endif

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   mdu_divider_if #(.XLEN(W)) bus ();

   mdu_divider #(
      .XLEN (W)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic signed [31:0] sdiv(input logic signed [31:0] a, b);
      return a / b;
   endfunction

   function automatic logic signed [31:0] srem(input logic signed [31:0] a, b);
      return a % b;
   endfunction

   // RV32M result rules, straight from the ISA definition.
   function automatic logic [31:0] ref_res(input logic [1:0] sel, input logic [31:0] a, b);
      if (b == 32'd0) return sel[1] ? a : 32'hFFFF_FFFF;
      if (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return sel[1] ? 32'd0 : 32'h8000_0000;
      if (sel[0]) return sel[1] ? (a % b) : (a / b);
      return sel[1] ? srem(a, b) : sdiv(a, b);
   endfunction

   function automatic int ref_lat(input logic [1:0] sel, input logic [31:0] a, b);
      if (b == 32'd0) return SpecLat;
      if (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SpecLat;
      return NormLat;
   endfunction

   // Model: m_cnt is the cycle index since the accepting edge (0 = idle).
   int          m_cnt = 0;
   int          m_lat = 0;
   logic [31:0] m_pend = '0;
   logic [31:0] m_hold = '0;

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_cnt  = 0;
         m_hold = '0;
      end else if (m_cnt == 0) begin
         if (bus.start_i) begin
            m_cnt  = 1;
            m_lat  = ref_lat(bus.divsel_i, bus.a_i, bus.b_i);
            m_pend = ref_res(bus.divsel_i, bus.a_i, bus.b_i);
         end
      end else if (m_cnt == m_lat) begin
         m_cnt = 0;
      end else begin
         m_cnt++;
         if (m_cnt == m_lat) m_hold = m_pend;
      end
   end

   always @(negedge clk_i) begin
      check("busy", 32'(bus.busy_o), 32'(m_cnt != 0));
      check("done", 32'(bus.done_o), 32'(m_cnt != 0 && m_cnt == m_lat));
      check("res", bus.res_o, m_hold);
   end

   task automatic run_op(input string name, input logic [1:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      check({name, " model"}, ref_res(sel, a, b), exp);
      @(negedge clk_i);
      bus.start_i  = 1'b1;
      bus.divsel_i = sel;
      bus.a_i      = a;
      bus.b_i      = b;
      @(negedge clk_i);
      bus.start_i = 1'b0;
      bus.a_i     = $urandom;
      bus.b_i     = $urandom;
      lat = 1;
      while (!bus.done_o && lat < 100) begin
         @(negedge clk_i);
         lat++;
      end
      check({name, " lat"}, 32'(lat), 32'(exp_lat));
      check({name, " res"}, bus.res_o, exp);
   endtask

   initial begin
      int k;
      bus.start_i  = 1'b0;
      bus.a_i      = '0;
      bus.b_i      = '0;
      bus.divsel_i = '0;
      #1 rst_i = 1'b1;
      #2;
      check("rst busy", 32'(bus.busy_o), 32'd0);
      check("rst done", 32'(bus.done_o), 32'd0);
      check("rst res", bus.res_o, 32'd0);
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;

      run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, NormLat);
      run_op("remu 100/7", REMU, 32'd100, 32'd7, 32'd2, NormLat);
      run_op("div -100/7", DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, NormLat);
      run_op("rem -100/7", REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, NormLat);
      run_op("div 100/-7", DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, NormLat);
      run_op("rem 100/-7", REM, 32'd100, 32'hFFFF_FFF9, 32'd2, NormLat);
      run_op("div -7/-2", DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, NormLat);
      run_op("rem -7/-2", REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, NormLat);
      run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SpecLat);
      run_op("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SpecLat);
      run_op("divu min/-1", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, NormLat);
      run_op("div min/2", DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, NormLat);
      run_op("divu max/1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, NormLat);
      run_op("divu x/0", DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, SpecLat);
      run_op("remu x/0", REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, SpecLat);
      run_op("div 5/0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SpecLat);
      run_op("rem 5/0", REM, 32'd5, 32'd0, 32'd5, SpecLat);
      run_op("div -7/0", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, SpecLat);
      run_op("rem -7/0", REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SpecLat);

      // start held high with churning operands: only E0 operands count
      @(negedge clk_i);
      bus.start_i  = 1'b1;
      bus.divsel_i = DIVU;
      bus.a_i      = 32'd1000;
      bus.b_i      = 32'd10;
      k = 0;
      while (k < 100) begin
         @(negedge clk_i);
         k++;
         if (bus.done_o) break;
         bus.divsel_i = 2'($urandom);
         bus.a_i      = $urandom;
         bus.b_i      = $urandom;
      end
      check("hold res", bus.res_o, 32'd100);
      check("hold lat", 32'(k), 32'(NormLat));
      bus.divsel_i = DIVU;
      bus.a_i      = 32'd50;
      bus.b_i      = 32'd5;
      @(negedge clk_i);
      check("no accept in done", 32'(bus.busy_o), 32'd0);
      @(negedge clk_i);
      check("accept after done", 32'(bus.busy_o), 32'd1);
      bus.start_i = 1'b0;
      k = 1;
      while (!bus.done_o && k < 100) begin
         @(negedge clk_i);
         k++;
      end
      check("b2b lat", 32'(k), 32'(NormLat));
      check("b2b res", bus.res_o, 32'd10);

      // reset in the middle of CALC
      @(negedge clk_i);
      bus.start_i  = 1'b1;
      bus.divsel_i = DIVU;
      bus.a_i      = 32'hFFFF_FFFF;
      bus.b_i      = 32'd3;
      @(posedge clk_i);
      #1 bus.start_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1 rst_i = 1'b1;
      #1;
      check("abort busy", 32'(bus.busy_o), 32'd0);
      check("abort done", 32'(bus.done_o), 32'd0);
      check("abort res", bus.res_o, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      run_op("divu 9/3", DIVU, 32'd9, 32'd3, 32'd3, NormLat);
      repeat (3) @(negedge clk_i);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
